pc_fetch_unit: RTL and testbench

Instruction-fetch sequencer that owns the 8-bit word-addressed program counter, drives instruction-memory addresses and hands fetched instructions to decode over a valid/ready handshake. It publishes `if_pc_next` (PC+1) as the `program_counter` operand of the branch target calculator. It consumes the resulting branch target (`br_target`) when a branch resolves taken, closing the loop between target computation and PC redirection.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/pc_fetch_unit.sv | 76 +++++++
 tb/tb_pc_fetch_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: datapath widths, reset vector and fetch states.
// Imported by the fetch unit and the branch target calculator.
package cpu_pkg;

    localparam int unsigned PC_W     = 8;
    localparam int unsigned INSTR_W  = 16;
    localparam logic [7:0]  RESET_PC = 8'h00;

    typedef enum logic {
        FS_RUN,
        FS_HALTED
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, addresses instruction memory and
// hands fetched words to decode through a one-entry valid/ready register.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned        P_PC_W     = PC_W,
    parameter int unsigned        P_INSTR_W  = INSTR_W,
    parameter logic [P_PC_W-1:0]  P_RESET_PC = P_PC_W'(RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [P_PC_W-1:0]     imem_addr,
    input  logic [P_INSTR_W-1:0]  imem_rdata,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [P_INSTR_W-1:0]  if_instr,
    output logic [P_PC_W-1:0]     if_pc,
    output logic [P_PC_W-1:0]     if_pc_next,
    input  logic                  br_taken,
    input  logic [P_PC_W-1:0]     br_target,
    input  logic                  halt,
    input  logic                  resume
);

    fetch_state_t           r_state;
    logic [P_PC_W-1:0]      r_pc;
    logic                   r_valid;
    logic [P_INSTR_W-1:0]   r_instr;
    logic [P_PC_W-1:0]      r_if_pc;
    logic [P_PC_W-1:0]      r_if_pc_next;

    logic                   w_load;
    logic [P_PC_W-1:0]      w_pc_inc;

    assign w_load   = !r_valid || if_ready;
    assign w_pc_inc = r_pc + P_PC_W'(1);

    // Branch outranks halt so a halt in the shadow of a taken branch
    // still parks the PC on the target for the eventual resume.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= FS_RUN;
            r_pc         <= P_RESET_PC;
            r_valid      <= 1'b0;
            r_instr      <= '0;
            r_if_pc      <= '0;
            r_if_pc_next <= '0;
        end else if (br_taken) begin
            r_pc    <= br_target;
            r_valid <= 1'b0;
            if (halt) begin
                r_state <= FS_HALTED;
            end
        end else if (halt) begin
            r_state <= FS_HALTED;
            r_valid <= 1'b0;
        end else if (r_state == FS_HALTED) begin
            if (resume) begin
                r_state <= FS_RUN;
            end
        end else if (w_load) begin
            r_valid      <= 1'b1;
            r_instr      <= imem_rdata;
            r_if_pc      <= r_pc;
            r_if_pc_next <= w_pc_inc;
            r_pc         <= w_pc_inc;
        end
    end

    assign imem_addr  = r_pc;
    assign if_valid   = r_valid;
    assign if_instr   = r_instr;
    assign if_pc      = r_if_pc;
    assign if_pc_next = r_if_pc_next;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; instruction memory returns 16'hA000 + addr.
// Outputs are sampled 1 time unit after each rising edge.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [7:0]  if_pc;
    logic [7:0]  if_pc_next;
    logic        br_taken;
    logic [7:0]  br_target;
    logic        halt;
    logic        resume;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 16'hA000 + {8'h00, imem_addr};

    pc_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_pc_next (if_pc_next),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .halt       (halt),
        .resume     (resume)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic [7:0] pc);
        chk({tag, " valid"}, {15'd0, if_valid}, 16'd1);
        chk({tag, " pc"}, {8'd0, if_pc}, {8'd0, pc});
        chk({tag, " pc_next"}, {8'd0, if_pc_next}, {8'd0, 8'(pc + 8'd1)});
        chk({tag, " instr"}, if_instr, 16'hA000 + {8'd0, pc});
    endtask

    initial begin
        rst_n     = 1'b0;
        if_ready  = 1'b1;
        br_taken  = 1'b0;
        br_target = 8'h00;
        halt      = 1'b0;
        resume    = 1'b0;

        step();
        chk("rst valid", {15'd0, if_valid}, 16'd0);
        chk("rst instr", if_instr, 16'h0000);
        chk("rst pc", {8'd0, if_pc}, 16'h0000);
        chk("rst pc_next", {8'd0, if_pc_next}, 16'h0000);
        chk("rst imem_addr", {8'd0, imem_addr}, 16'h0000);

        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_fetch("seq", 8'(i));
            chk("seq imem_addr", {8'd0, imem_addr}, 16'(i + 1));
        end

        // if_pc = 05, stall three cycles
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_fetch("stall", 8'h05);
            chk("stall imem_addr", {8'd0, imem_addr}, 16'h0006);
        end
        if_ready = 1'b1;
        step();
        chk_fetch("release", 8'h06);

        for (int i = 7; i <= 16; i++) begin
            step();
            chk_fetch("run", 8'(i));
        end

        // if_pc = 10, redirect while decode is stalled
        if_ready  = 1'b0;
        br_taken  = 1'b1;
        br_target = 8'h40;
        step();
        chk("br flush", {15'd0, if_valid}, 16'd0);
        chk("br imem_addr", {8'd0, imem_addr}, 16'h0040);
        br_taken = 1'b0;
        if_ready = 1'b1;
        step();
        chk_fetch("br target", 8'h40);

        br_taken  = 1'b1;
        br_target = 8'hFE;
        step();
        chk("wrap flush", {15'd0, if_valid}, 16'd0);
        br_taken = 1'b0;
        step();
        chk_fetch("wrap FE", 8'hFE);
        step();
        chk_fetch("wrap FF", 8'hFF);
        chk("wrap pc_next FF", {8'd0, if_pc_next}, 16'h0000);
        chk("wrap imem_addr", {8'd0, imem_addr}, 16'h0000);
        step();
        chk_fetch("wrap 00", 8'h00);
        step();
        chk_fetch("wrap 01", 8'h01);

        halt      = 1'b1;
        br_taken  = 1'b1;
        br_target = 8'h20;
        step();
        chk("halt valid", {15'd0, if_valid}, 16'd0);
        chk("halt imem_addr", {8'd0, imem_addr}, 16'h0020);
        halt     = 1'b0;
        br_taken = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halted valid", {15'd0, if_valid}, 16'd0);
            chk("halted imem_addr", {8'd0, imem_addr}, 16'h0020);
        end
        resume = 1'b1;
        step();
        chk("resume edge valid", {15'd0, if_valid}, 16'd0);
        resume = 1'b0;
        step();
        chk_fetch("resume", 8'h20);

        if_ready = 1'b0;
        step();
        chk_fetch("pre-rst stall", 8'h20);
        rst_n = 1'b0;
        step();
        chk("mid rst valid", {15'd0, if_valid}, 16'd0);
        chk("mid rst instr", if_instr, 16'h0000);
        chk("mid rst pc", {8'd0, if_pc}, 16'h0000);
        chk("mid rst pc_next", {8'd0, if_pc_next}, 16'h0000);
        chk("mid rst imem_addr", {8'd0, imem_addr}, 16'h0000);
        rst_n    = 1'b1;
        if_ready = 1'b1;
        step();
        chk_fetch("post rst", 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
